// File: rtl/oh_arb_pkg.sv
// Shared types and constants for the one-hot round-robin arbiter family.
// Holds the state encoding, default sizes and the index width helper.
package oh_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEF_N       = 4;
    localparam int DEF_MAXHOLD = 16;

    // Binary index width for n requesters, never below one bit.
    function automatic int oh_arb_gw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oh_arb_rrpick.sv
// Rotating priority pick: first requester at or after ptr, wrapping.
// Purely combinational so other arbiters can reuse it.
module oh_arb_rrpick
    import oh_arb_pkg::*;
#(
    parameter int    N    = DEF_N,
    parameter string PROP = "DEFAULT"
) (
    input  logic [N-1:0]              req,
    input  logic [oh_arb_gw(N)-1:0]   ptr,
    output logic [oh_arb_gw(N)-1:0]   pick,
    output logic                      found
);

    localparam int GW = oh_arb_gw(N);

    int w_idx;

    // Circular search from ptr; the first hit wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        w_idx = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!found && req[w_idx]) begin
                found = 1'b1;
                pick  = GW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/oh_arb_rr.sv
// Round-robin arbiter with registered one-hot grant and per-line hold.
// Define OH_ARB_TIMEOUT_EN to force-release holds after MAXHOLD cycles.
module oh_arb_rr
    import oh_arb_pkg::*;
#(
    parameter int    N       = DEF_N,
    parameter int    MAXHOLD = DEF_MAXHOLD,
    parameter string PROP    = "DEFAULT"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N-1:0]            req,
    input  logic [N-1:0]            hold,
    input  logic                    stall,
    output logic [N-1:0]            grant,
    output logic                    gvalid,
    output logic [oh_arb_gw(N)-1:0] gid,
    output logic                    timeout
);

    localparam int GW = oh_arb_gw(N);

    arb_state_t     r_state;
    logic [GW-1:0]  r_ptr;
    logic [GW-1:0]  r_gid;
    logic [N-1:0]   r_grant;
    logic           r_gvalid;

    logic [GW-1:0]  w_pick;
    logic           w_found;
    logic           w_retain;
    logic           w_force;
    logic           w_keep;
    logic           w_new;
    logic [N-1:0]   w_onehot;
    logic [GW-1:0]  w_ptr_nxt;

    oh_arb_rrpick #(
        .N    (N),
        .PROP (PROP)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .pick  (w_pick),
        .found (w_found)
    );

    assign w_retain  = (r_state == BUSY) && req[r_gid] && hold[r_gid];
    assign w_keep    = w_retain && !w_force;
    assign w_new     = !w_keep && !stall && w_found;
    assign w_onehot  = {{(N-1){1'b0}}, 1'b1} << w_pick;
    assign w_ptr_nxt = (w_pick == GW'(N - 1)) ? '0 : w_pick + 1'b1;

`ifdef OH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAXHOLD + 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    assign w_force = w_retain && (r_cnt == CW'(MAXHOLD - 1));

    // Count consecutive retained cycles; any other outcome restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if (w_keep) r_cnt <= r_cnt + 1'b1;
            else        r_cnt <= '0;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    // Grant state: retain, re-pick back-to-back, or drop to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_gid    <= '0;
            r_grant  <= '0;
            r_gvalid <= 1'b0;
        end else if (w_keep) begin
            r_state  <= BUSY;
        end else if (w_new) begin
            r_state  <= BUSY;
            r_grant  <= w_onehot;
            r_gid    <= w_pick;
            r_gvalid <= 1'b1;
            r_ptr    <= w_ptr_nxt;
        end else begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_gid    <= '0;
            r_gvalid <= 1'b0;
        end
    end

    assign grant  = r_grant;
    assign gvalid = r_gvalid;
    assign gid    = r_gid;

endmodule

// File: tb/tb_oh_arb_rr.sv
// Directed bench for oh_arb_rr with N=4, MAXHOLD=4.
// Timeout scenario depends on OH_ARB_TIMEOUT_EN being defined.
module tb_oh_arb_rr;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] hold = '0;
    logic       stall = 1'b0;
    logic [3:0] grant;
    logic       gvalid;
    logic [1:0] gid;
    logic       timeout;

    int n_pass = 0;
    int n_total = 0;

    oh_arb_rr #(
        .N       (4),
        .MAXHOLD (4),
        .PROP    ("DEFAULT")
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .hold    (hold),
        .stall   (stall),
        .grant   (grant),
        .gvalid  (gvalid),
        .gid     (gid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; hold = '0; stall = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({grant, gvalid, gid, timeout} !== 8'b0)
            $display("FAIL reset_outs: got %b want 00000000",
                     {grant, gvalid, gid, timeout});
        else n_pass++;
    endtask

    task automatic test_rr_all();
        logic [3:0] eg;
        req = 4'b1111; hold = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            eg = 4'b0001 << (i % 4);
            n_total++;
            if (grant !== eg || gvalid !== 1'b1 ||
                gid !== 2'(i % 4) || timeout !== 1'b0)
                $display("FAIL rr_all[%0d]: got g=%b v=%b id=%0d t=%b want g=%b v=1 id=%0d t=0",
                         i, grant, gvalid, gid, timeout, eg, i % 4);
            else n_pass++;
        end
        req = '0;
        tick();
        n_total++;
        if (grant !== 4'b0 || gvalid !== 1'b0 || gid !== 2'd0)
            $display("FAIL rr_idle: got g=%b v=%b id=%0d want 0000/0/0",
                     grant, gvalid, gid);
        else n_pass++;
    endtask

    task automatic test_hold();
        req = 4'b0100; hold = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (grant !== 4'b0100 || gid !== 2'd2)
                $display("FAIL hold[%0d]: got g=%b id=%0d want 0100/2",
                         i, grant, gid);
            else n_pass++;
        end
        req = 4'b0101; hold = '0;
        tick();
        n_total++;
        if (grant !== 4'b0001 || gid !== 2'd0 || gvalid !== 1'b1)
            $display("FAIL hold_release: got g=%b id=%0d v=%b want 0001/0/1",
                     grant, gid, gvalid);
        else n_pass++;
        req = '0;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1'b1; req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (grant !== 4'b0 || gvalid !== 1'b0)
                $display("FAIL stall_block[%0d]: got g=%b v=%b want 0000/0",
                         i, grant, gvalid);
            else n_pass++;
        end
        stall = 1'b0;
        tick();
        n_total++;
        if (grant !== 4'b0001 || gid !== 2'd0)
            $display("FAIL stall_free: got g=%b id=%0d want 0001/0",
                     grant, gid);
        else n_pass++;
        req = '0;
        tick();
    endtask

    task automatic test_wrap();
        req = 4'b1000;
        tick();
        n_total++;
        if (grant !== 4'b1000 || gid !== 2'd3)
            $display("FAIL wrap_g3: got g=%b id=%0d want 1000/3", grant, gid);
        else n_pass++;
        req = 4'b1001;
        tick();
        n_total++;
        if (grant !== 4'b0001 || gid !== 2'd0)
            $display("FAIL wrap_g0: got g=%b id=%0d want 0001/0", grant, gid);
        else n_pass++;
        req = '0;
        tick();
    endtask

    task automatic test_sole_winner();
        req = 4'b0100; hold = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (grant !== 4'b0100 || gvalid !== 1'b1)
                $display("FAIL sole[%0d]: got g=%b v=%b want 0100/1",
                         i, grant, gvalid);
            else n_pass++;
        end
        req = '0;
        tick();
    endtask

    task automatic test_retain_stall_reset();
        req = 4'b0010; hold = 4'b0010;
        tick();
        n_total++;
        if (grant !== 4'b0010)
            $display("FAIL retain_start: got g=%b want 0010", grant);
        else n_pass++;
        stall = 1'b1; req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (grant !== 4'b0010 || gid !== 2'd1)
                $display("FAIL retain_stall[%0d]: got g=%b id=%0d want 0010/1",
                         i, grant, gid);
            else n_pass++;
        end
        stall = 1'b0;
        reset = 1'b1;
        tick();
        n_total++;
        if (grant !== 4'b0 || gid !== 2'd0 || gvalid !== 1'b0)
            $display("FAIL mid_reset: got g=%b id=%0d v=%b want 0000/0/0",
                     grant, gid, gvalid);
        else n_pass++;
        reset = 1'b0; req = 4'b1010; hold = '0;
        tick();
        n_total++;
        if (grant !== 4'b0010 || gid !== 2'd1)
            $display("FAIL post_reset_ptr: got g=%b id=%0d want 0010/1",
                     grant, gid);
        else n_pass++;
        req = '0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0011; hold = 4'b0001;
`ifdef OH_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (grant !== 4'b0001 || timeout !== 1'b0)
                $display("FAIL to_hold[%0d]: got g=%b t=%b want 0001/0",
                         i, grant, timeout);
            else n_pass++;
        end
        tick();
        n_total++;
        if (grant !== 4'b0010 || timeout !== 1'b1)
            $display("FAIL to_fire: got g=%b t=%b want 0010/1", grant, timeout);
        else n_pass++;
        tick();
        n_total++;
        if (timeout !== 1'b0)
            $display("FAIL to_pulse: got t=%b want 0", timeout);
        else n_pass++;
`else
        for (int i = 0; i < 10; i++) begin
            tick();
            n_total++;
            if (grant !== 4'b0001 || timeout !== 1'b0)
                $display("FAIL hold_forever[%0d]: got g=%b t=%b want 0001/0",
                         i, grant, timeout);
            else n_pass++;
        end
`endif
        req = '0; hold = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rr_all();
        test_hold();
        test_stall();
        test_wrap();
        test_sole_winner();
        test_retain_stall_reset();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
